// File: rtl/dmac_ch_sched.sv
// DMA channel scheduler: two-class round-robin arbitration over four channels
// with beat budget, watchdog release and sticky completion flags.
module dmac_ch_sched #(
    parameter int unsigned MAX_BEATS = 8,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ch_req,
    input  logic [3:0] ch_prio,
    input  logic       req_done,
    input  logic [3:0] ch_done,
    input  logic       abort,
    input  logic [3:0] irq_clr,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic [3:0] irq_done,
    output logic       wd_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_GRANT,
        S_REL
    } state_t;

    localparam logic [7:0]  BEAT_LAST = 8'(MAX_BEATS - 1);
    localparam logic [15:0] IDLE_MAX  = 16'(TIMEOUT);

    state_t      state;
    state_t      state_nx;
    logic [1:0]  rr_ptr;
    logic [7:0]  beat_cnt;
    logic [15:0] idle_cnt;
    logic [3:0]  elig;
    logic [1:0]  idx;
    logic [1:0]  win_id;
    logic        win_ok;
    logic [1:0]  id_nx;
    logic        beat_last;
    logic        wd_hit;
    logic        rel;

    // High-priority requesters shadow the rest; search starts after last winner
    always_comb begin
        elig = ch_req & ch_prio;
        if (elig == 4'b0000) begin
            elig = ch_req;
        end
        win_ok = 1'b0;
        win_id = rr_ptr;
        idx    = rr_ptr;
        for (int i = 1; i <= 4; i++) begin
            idx = rr_ptr + 2'(i);
            if (!win_ok && elig[idx]) begin
                win_ok = 1'b1;
                win_id = idx;
            end
        end
    end

    always_comb begin
        beat_last = req_done && (beat_cnt == BEAT_LAST);
        wd_hit    = (idle_cnt == IDLE_MAX);
        rel       = beat_last || ch_done[grant_id] || !ch_req[grant_id]
                    || abort || wd_hit;
        state_nx  = state;
        id_nx     = (state == S_ARB) ? win_id : grant_id;
        unique case (state)
            S_IDLE:  if (ch_req != 4'b0000 && !abort) state_nx = S_ARB;
            S_ARB:   state_nx = (abort || !win_ok) ? S_IDLE : S_GRANT;
            S_GRANT: if (rel) state_nx = S_REL;
            S_REL:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            grant    <= 4'b0000;
            grant_id <= 2'd0;
            busy     <= 1'b0;
            irq_done <= 4'b0000;
            wd_err   <= 1'b0;
            beat_cnt <= 8'd0;
            idle_cnt <= 16'd0;
            rr_ptr   <= 2'd3;
        end else begin
            state    <= state_nx;
            busy     <= (state_nx != S_IDLE);
            irq_done <= (irq_done & ~irq_clr) | ch_done;
            grant    <= (state_nx == S_GRANT) ? (4'b0001 << id_nx) : 4'b0000;
            if (state == S_ARB && win_ok) begin
                grant_id <= win_id;
            end
            if (state == S_GRANT) begin
                if (req_done) begin
                    beat_cnt <= beat_cnt + 8'd1;
                    idle_cnt <= 16'd0;
                end else if (!wd_hit) begin
                    idle_cnt <= idle_cnt + 16'd1;
                end
                if (wd_hit) begin
                    wd_err <= 1'b1;
                end
            end
            if (state == S_REL) begin
                rr_ptr   <= grant_id;
                beat_cnt <= 8'd0;
                idle_cnt <= 16'd0;
            end
        end
    end

endmodule

// File: tb/tb_dmac_ch_sched.sv
// Self-checking bench for dmac_ch_sched: vector table for arbitration order,
// hand sequences for completion, abort, watchdog and reset corners.
module tb_dmac_ch_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ch_req = '0;
    logic [3:0] ch_prio = '0;
    logic       req_done = 1'b0;
    logic [3:0] ch_done = '0;
    logic       abort = 1'b0;
    logic [3:0] irq_clr = '0;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic [3:0] irq_done;
    logic       wd_err;

    int n_pass  = 0;
    int n_total = 0;

    logic [3:0] sb[$];

    typedef struct {
        logic [3:0] req;
        logic [3:0] prio;
        int         nbeats;
        logic [3:0] req_after;
        logic [3:0] exp;
        int         lat;
    } vec_t;

    vec_t tbl[10];

    always #5 clk = ~clk;

    dmac_ch_sched #(.MAX_BEATS(8), .TIMEOUT(15)) dut (
        .clk      (clk),
        .rst      (rst),
        .ch_req   (ch_req),
        .ch_prio  (ch_prio),
        .req_done (req_done),
        .ch_done  (ch_done),
        .abort    (abort),
        .irq_clr  (irq_clr),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .irq_done (irq_done),
        .wd_err   (wd_err)
    );

    // grant is one-hot or zero and only present while busy
    always @(negedge clk) begin
        n_total++;
        if ($countones(grant) > 1 || (grant != 4'b0 && !busy))
            $display("FAIL grant_onehot: got grant=%b busy=%b want onehot&busy",
                     grant, busy);
        else
            n_pass++;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] idx_of(logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        if (oh[1]) r = 2'd1;
        if (oh[2]) r = 2'd2;
        if (oh[3]) r = 2'd3;
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_grant", grant, 4'b0);
        chk("rst_id", grant_id, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_irq", irq_done, 4'b0);
        chk("rst_wd", wd_err, 1'b0);
        rst = 1'b0;
        tick();
    endtask

    task automatic expect_grant(string name, logic [3:0] exp, int lat);
        int n;
        logic [3:0] e;
        n = 0;
        sb.push_back(exp);
        while (grant == 4'b0 && n < 12) begin
            tick();
            n++;
        end
        e = sb.pop_front();
        chk({name, "_grant"}, grant, e);
        chk({name, "_lat"}, n, lat);
        chk({name, "_id"}, grant_id, idx_of(e));
    endtask

    task automatic run_vec(int k);
        vec_t v;
        v = tbl[k];
        ch_req  = v.req;
        ch_prio = v.prio;
        expect_grant($sformatf("vec%0d", k), v.exp, v.lat);
        for (int b = 0; b < v.nbeats; b++) begin
            req_done = 1'b1;
            tick();
            if (b < 7) chk($sformatf("vec%0d_hold", k), grant, v.exp);
        end
        req_done = 1'b0;
        if (v.nbeats < 8) begin
            ch_req = v.req_after;
            tick();
        end
        chk($sformatf("vec%0d_rel_grant", k), grant, 4'b0);
        chk($sformatf("vec%0d_rel_busy", k), busy, 1'b1);
    endtask

    initial begin
        int cnt;
        tbl[0] = '{4'b1111, 4'b0000, 8, 4'b1111, 4'b0001, 2};
        tbl[1] = '{4'b1111, 4'b0000, 8, 4'b1111, 4'b0010, 3};
        tbl[2] = '{4'b1111, 4'b0000, 8, 4'b1111, 4'b0100, 3};
        tbl[3] = '{4'b1111, 4'b0000, 8, 4'b1111, 4'b1000, 3};
        tbl[4] = '{4'b1111, 4'b0000, 8, 4'b1111, 4'b0001, 3};
        tbl[5] = '{4'b1111, 4'b0100, 8, 4'b1111, 4'b0100, 3};
        tbl[6] = '{4'b1111, 4'b0100, 8, 4'b1111, 4'b0100, 3};
        tbl[7] = '{4'b1111, 4'b0100, 2, 4'b1011, 4'b0100, 3};
        tbl[8] = '{4'b1011, 4'b0100, 8, 4'b1011, 4'b1000, 3};
        tbl[9] = '{4'b1011, 4'b0100, 8, 4'b1011, 4'b0001, 3};

        do_reset();
        tick();
        // stray beats in IDLE must not shorten the next grant
        req_done = 1'b1;
        tick();
        tick();
        tick();
        req_done = 1'b0;
        ch_req = 4'b0001;
        sb.push_back(4'b0001);
        tick();
        chk("b35_busy_t1", busy, 1'b1);
        chk("b35_grant_t1", grant, 4'b0);
        tick();
        chk("b35_grant_t2", grant, sb.pop_front());
        for (int b = 0; b < 8; b++) begin
            req_done = 1'b1;
            tick();
            if (b < 7) chk("b35_hold", grant, 4'b0001);
        end
        req_done = 1'b0;
        ch_req = 4'b0000;
        chk("b35_rel_grant", grant, 4'b0);
        chk("b35_rel_busy", busy, 1'b1);
        tick();
        chk("b35_idle_busy", busy, 1'b0);

        do_reset();
        for (int k = 0; k < 10; k++) run_vec(k);
        ch_req = 4'b0000;
        ch_prio = 4'b0000;
        tick();
        tick();

        ch_req = 4'b0010;
        expect_grant("b38", 4'b0010, 2);
        req_done = 1'b1;
        tick();
        tick();
        req_done = 1'b0;
        ch_done = 4'b1000;
        tick();
        ch_done = 4'b0000;
        chk("b38_other_done_grant", grant, 4'b0010);
        chk("b38_other_done_irq", irq_done, 4'b1000);
        req_done = 1'b1;
        ch_done = 4'b0010;
        tick();
        req_done = 1'b0;
        ch_done = 4'b0000;
        chk("b38_rel_grant", grant, 4'b0);
        chk("b38_rel_irq", irq_done, 4'b1010);
        ch_req = 4'b0000;
        tick();
        chk("b38_idle_busy", busy, 1'b0);
        irq_clr = 4'b0010;
        ch_done = 4'b0010;
        tick();
        irq_clr = 4'b0000;
        ch_done = 4'b0000;
        chk("b38_set_wins", irq_done, 4'b1010);
        irq_clr = 4'b1010;
        tick();
        irq_clr = 4'b0000;
        chk("b38_clr", irq_done, 4'b0000);

        ch_req = 4'b0001;
        expect_grant("abt", 4'b0001, 2);
        req_done = 1'b1;
        tick();
        req_done = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        ch_req = 4'b0000;
        chk("abt_grant", grant, 4'b0);
        chk("abt_busy", busy, 1'b1);
        chk("abt_wd", wd_err, 1'b0);
        tick();
        chk("abt_idle", busy, 1'b0);

        ch_req = 4'b0001;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        ch_req = 4'b0000;
        chk("abt_idle_busy", busy, 1'b0);
        tick();
        chk("abt_idle_grant", grant, 4'b0);
        ch_req = 4'b0001;
        tick();
        chk("abt_arb_busy1", busy, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        ch_req = 4'b0000;
        chk("abt_arb_busy0", busy, 1'b0);
        chk("abt_arb_grant", grant, 4'b0);
        tick();
        chk("abt_arb_grant2", grant, 4'b0);

        ch_req = 4'b0100;
        expect_grant("wd", 4'b0100, 2);
        chk("wd_pre", wd_err, 1'b0);
        // idle_cnt hits TIMEOUT after 15 idle edges; release on the 16th
        cnt = 1;
        for (int i = 0; i < 40 && grant != 4'b0; i++) begin
            tick();
            if (grant != 4'b0) cnt++;
        end
        ch_req = 4'b0000;
        chk("wd_cycles", cnt, 16);
        chk("wd_set", wd_err, 1'b1);
        tick();
        tick();
        chk("wd_sticky", wd_err, 1'b1);

        ch_req = 4'b1111;
        expect_grant("b40", 4'b1000, 2);
        ch_done = 4'b0001;
        tick();
        ch_done = 4'b0000;
        chk("b40_irq_pre", irq_done, 4'b0001);
        #1;
        rst = 1'b1;
        #1;
        chk("b40_async_grant", grant, 4'b0);
        chk("b40_async_irq", irq_done, 4'b0);
        chk("b40_async_wd", wd_err, 1'b0);
        chk("b40_async_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        expect_grant("b40_after", 4'b0001, 2);
        ch_req = 4'b0000;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmac_ch_sched.md
DMAC_CH_SCHED -- requirements
Module: dmac_ch_sched

Interface
REQ-001 Parameter MAX_BEATS, default 8, beats (req_done pulses) per grant before forced re-arbitration; legal 1..255.
REQ-002 Parameter TIMEOUT, default 1023, idle cycles without req_done in GRANT before watchdog release; legal 1..65535.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 ch_req  in  4  channel i armed and wants the bus (config enable and not finished), level.
REQ-006 ch_prio  in  4  1 = channel i in high-priority class, level.
REQ-007 req_done  in  1  one-cycle pulse per completed beat from the channel controller.
REQ-008 ch_done  in  4  one-cycle pulse, channel i transfer complete.
REQ-009 abort  in  1  one-cycle pulse, drop current grant.
REQ-010 irq_clr  in  4  one-cycle pulse, clear irq_done[i].
REQ-011 grant  out  4  one-hot (or zero) channel enable to the controller en_0..en_3.
REQ-012 grant_id  out  2  index of last winner; valid while busy.
REQ-013 busy  out  1  high in ARB, GRANT, RELEASE.
REQ-014 irq_done  out  4  sticky completion flags.
REQ-015 wd_err  out  1  sticky watchdog flag; cleared only by reset.

Function
REQ-016 FSM states IDLE, ARB, GRANT, RELEASE; all outputs registered.
REQ-017 IDLE: ch_req!=0 and abort==0 -> ARB next cycle; else stay.
REQ-018 ARB (1 cycle): winner latched into grant_id; GRANT next cycle; if ch_req==0 in ARB -> IDLE, no grant.
REQ-019 Winner: any eligible ch_req&ch_prio -> search that set, else all ch_req; within set round-robin from rr_ptr+1 upward, wrapping 3->0.
REQ-020 Latency: ch_req seen in IDLE at cycle t -> grant asserted at t+2.
REQ-021 GRANT: grant = one-hot(grant_id); beat_cnt increments per req_done; idle_cnt increments each cycle without req_done, cleared on req_done.
REQ-022 GRANT -> RELEASE when any of: beat_cnt reaches MAX_BEATS (counting current req_done); ch_done[grant_id]; ch_req[grant_id]==0; abort; idle_cnt==TIMEOUT.
REQ-023 RELEASE (1 cycle): grant=0 (dead cycle so controller FSMs observe enable drop); rr_ptr<=grant_id; beat_cnt, idle_cnt <=0; -> IDLE.
REQ-024 Watchdog release sets wd_err; other release causes do not touch it.
REQ-025 req_done and ch_done[grant_id] same cycle: beat counted, release taken, irq_done set.
REQ-026 ch_done for a non-granted channel: sets irq_done only, no state change.
REQ-027 irq_done[i] set on ch_done[i]; cleared on irq_clr[i]; simultaneous set and clear -> set wins.
REQ-028 req_done outside GRANT ignored (no count).
REQ-029 abort in IDLE or ARB: return/stay IDLE next cycle, no grant issued; abort in RELEASE: no effect.
REQ-030 beat_cnt width 8, idle_cnt width 16; neither wraps (saturate at release condition).
REQ-031 grant never has more than one bit set; grant!=0 only in GRANT.

Reset
REQ-032 rst high: state IDLE, grant=0, grant_id=0, busy=0, irq_done=0, wd_err=0, beat_cnt=0, idle_cnt=0, rr_ptr=3 (channel 0 wins first tie).
REQ-033 rst asserted mid-grant: grant drops asynchronously same cycle; no completion flags set.
REQ-034 After rst deasserts, first arbitration no earlier than next rising edge.

Verification
REQ-035 Reset, ch_req=0001 at t -> grant=0001 at t+2, busy=1 at t+1; 8 req_done pulses -> grant=0 in RELEASE, IDLE next cycle.
REQ-036 ch_req=1111, ch_prio=0 held, 8 beats each grant -> grant order 0001,0010,0100,1000,0001, one zero cycle between grants.
REQ-037 ch_req=1111, ch_prio=0100 -> channel 2 granted every arbitration until ch_req[2] drops, then round-robin resumes at channel 3.
REQ-038 Channel 1 granted, req_done and ch_done[1] same cycle at beat 3 -> release next cycle, irq_done=0010; irq_clr[1] and ch_done[1] same cycle -> irq_done[1] stays 1.
REQ-039 TIMEOUT=15, grant held with no req_done -> release after 15 idle cycles, wd_err=1 sticky; abort mid-grant -> grant=0 next cycle, wd_err unchanged.
REQ-040 rst pulsed during GRANT -> grant=0 immediately, irq_done=0, next grant goes to channel 0 when ch_req=1111.
